// File: rtl/bounce_pkg.sv
// Shared constants and FSM encoding for the capsule bounce controller.
package bounce_pkg;

  localparam int unsigned VW = 6;
  localparam int unsigned CW = 12;

  localparam int XMIN        = 0;
  localparam int XMAX        = 639;
  localparam int YMIN        = 0;
  localparam int YMAX        = 479;
  localparam int RADIUS      = 16;
  localparam int GRAV_PERIOD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KICK,
    ST_SETTLE,
    ST_CHECK,
    ST_APPLY
  } state_t;

endpackage

// File: rtl/bounce_controller_sat_neg.sv
// Combinational saturating negate: the most negative value maps to the most positive.
module sat_neg #(
  parameter int unsigned W = 6
) (
  input  logic signed [W-1:0] a,
  output logic signed [W-1:0] neg_c
);

  localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};

  assign neg_c = (a == MIN_V) ? MAX_V : W'(-a);

endmodule

// File: rtl/bounce_controller.sv
// Frame-driven motion initiator: kicks the kinematics engine, then reflects velocity/spin on wall hits.
// Optional gravity step enabled by defining BOUNCE_GRAVITY_EN.
module bounce_controller
  import bounce_pkg::*;
#(
  parameter int SETTLE  = 160,
  parameter int INIT_VX = 5,
  parameter int INIT_VY = -3,
  parameter int INIT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 run,
  input  logic [9:0]           center_x,
  input  logic [9:0]           center_y,
  input  logic [5:0]           dx,
  input  logic [5:0]           dy,
  output logic                 update,
  output logic signed [VW-1:0] vx,
  output logic signed [VW-1:0] vy,
  output logic signed [VW-1:0] w,
  output logic                 busy,
  output logic                 bounce_x,
  output logic                 bounce_y,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(SETTLE + 1);
  localparam logic signed [VW-1:0] INIT_VX_V = VW'(INIT_VX);
  localparam logic signed [VW-1:0] INIT_VY_V = VW'(INIT_VY);
  localparam logic signed [VW-1:0] INIT_W_V  = VW'(INIT_W);
  localparam logic signed [CW-1:0] XMIN_S = CW'(XMIN);
  localparam logic signed [CW-1:0] XMAX_S = CW'(XMAX);
  localparam logic signed [CW-1:0] YMIN_S = CW'(YMIN);
  localparam logic signed [CW-1:0] YMAX_S = CW'(YMAX);
  localparam logic signed [CW-1:0] RAD_S  = CW'(RADIUS);

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  logic signed [VW-1:0] vx_d, vy_d, w_d;
  logic signed [VW-1:0] neg_vx_c, neg_vy_c, neg_w_c;
  logic update_d, busy_d, bounce_x_d, bounce_y_d, overrun_d;

`ifdef BOUNCE_GRAVITY_EN
  localparam int unsigned GW = (GRAV_PERIOD > 2) ? $clog2(GRAV_PERIOD) : 1;
  localparam logic signed [VW-1:0] V_MAX = {1'b0, {(VW-1){1'b1}}};
  logic [GW-1:0] grav_q, grav_d;
  logic grav_pend_q, grav_pend_d;
`endif

  // Wall geometry in signed work width; inputs are zero-extended.
  logic signed [CW-1:0] cx_s, cy_s, dx_s, dy_s;
  logic signed [CW-1:0] left_c, right_c, top_c, bottom_c;
  logic hit_x_c, hit_y_c;

  assign cx_s     = CW'(center_x);
  assign cy_s     = CW'(center_y);
  assign dx_s     = CW'(dx);
  assign dy_s     = CW'(dy);
  assign left_c   = cx_s - dx_s - RAD_S;
  assign right_c  = cx_s + dx_s + RAD_S;
  assign top_c    = cy_s - dy_s - RAD_S;
  assign bottom_c = cy_s + dy_s + RAD_S;
  assign hit_x_c  = ((left_c < XMIN_S) && vx[VW-1]) ||
                    ((right_c > XMAX_S) && !vx[VW-1] && (vx != '0));
  assign hit_y_c  = ((top_c < YMIN_S) && vy[VW-1]) ||
                    ((bottom_c > YMAX_S) && !vy[VW-1] && (vy != '0));

  sat_neg #(.W(VW)) u_neg_vx (.a(vx), .neg_c(neg_vx_c));
  sat_neg #(.W(VW)) u_neg_vy (.a(vy), .neg_c(neg_vy_c));
  sat_neg #(.W(VW)) u_neg_w  (.a(w),  .neg_c(neg_w_c));

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hit_x_d    = hit_x_q;
    hit_y_d    = hit_y_q;
    vx_d       = vx;
    vy_d       = vy;
    w_d        = w;
    bounce_x_d = 1'b0;
    bounce_y_d = 1'b0;
    overrun_d  = overrun | (frame_tick && (state_q != ST_IDLE));
`ifdef BOUNCE_GRAVITY_EN
    grav_d      = grav_q;
    grav_pend_d = grav_pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (frame_tick && run) begin
          state_d = ST_KICK;
`ifdef BOUNCE_GRAVITY_EN
          if (grav_q == GW'(GRAV_PERIOD - 1)) begin
            grav_d      = '0;
            grav_pend_d = 1'b1;
          end else begin
            grav_d = grav_q + GW'(1);
          end
`endif
        end
      end
      ST_KICK: begin
        cnt_d   = CNT_W'(SETTLE - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CHECK: begin
        hit_x_d = hit_x_c;
        hit_y_d = hit_y_c;
        state_d = ST_APPLY;
      end
      ST_APPLY: begin
        if (hit_x_q) begin
          vx_d       = neg_vx_c;
          bounce_x_d = 1'b1;
        end
        if (hit_y_q) begin
          vy_d       = neg_vy_c;
          bounce_y_d = 1'b1;
        end
        if (hit_x_q || hit_y_q) w_d = neg_w_c;
`ifdef BOUNCE_GRAVITY_EN
        if (grav_pend_q) begin
          vy_d        = (vy_d == V_MAX) ? V_MAX : vy_d + VW'(1);
          grav_pend_d = 1'b0;
        end
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    update_d = (state_d == ST_KICK);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hit_x_q  <= 1'b0;
      hit_y_q  <= 1'b0;
      vx       <= INIT_VX_V;
      vy       <= INIT_VY_V;
      w        <= INIT_W_V;
      update   <= 1'b0;
      busy     <= 1'b0;
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      overrun  <= 1'b0;
`ifdef BOUNCE_GRAVITY_EN
      grav_q      <= '0;
      grav_pend_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hit_x_q  <= hit_x_d;
      hit_y_q  <= hit_y_d;
      vx       <= vx_d;
      vy       <= vy_d;
      w        <= w_d;
      update   <= update_d;
      busy     <= busy_d;
      bounce_x <= bounce_x_d;
      bounce_y <= bounce_y_d;
      overrun  <= overrun_d;
`ifdef BOUNCE_GRAVITY_EN
      grav_q      <= grav_d;
      grav_pend_q <= grav_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_bounce_controller.sv
// Directed bench for bounce_controller; expected gravity result depends on BOUNCE_GRAVITY_EN.
module tb_bounce_controller;

  logic clk = 1'b0;
  logic rst, run, tick_a, tick_b;
  logic [9:0] center_x, center_y;
  logic [5:0] dx, dy;

  logic upd_a, busy_a, bx_a, by_a, ovr_a;
  logic upd_b, busy_b, bx_b, by_b, ovr_b;
  logic signed [5:0] vx_a, vy_a, w_a, vx_b, vy_b, w_b;

  int checks = 0;
  int failures = 0;
  int last_n, last_ups;

  always #5 clk = ~clk;

  bounce_controller u_a (
    .clk(clk), .rst(rst), .frame_tick(tick_a), .run(run),
    .center_x(center_x), .center_y(center_y), .dx(dx), .dy(dy),
    .update(upd_a), .vx(vx_a), .vy(vy_a), .w(w_a), .busy(busy_a),
    .bounce_x(bx_a), .bounce_y(by_a), .overrun(ovr_a)
  );

  bounce_controller #(.INIT_VX(-32), .INIT_VY(30), .INIT_W(2)) u_b (
    .clk(clk), .rst(rst), .frame_tick(tick_b), .run(run),
    .center_x(center_x), .center_y(center_y), .dx(dx), .dy(dy),
    .update(upd_b), .vx(vx_b), .vy(vy_b), .w(w_b), .busy(busy_b),
    .bounce_x(bx_b), .bounce_y(by_b), .overrun(ovr_b)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One frame on instance sel (0=a, 1=b); optional extra tick at busy cycle `extra`.
  task automatic frame(input bit sel, input int extra);
    int n;
    int ups;
    logic b;
    n = 0;
    ups = 0;
    @(negedge clk);
    if (sel) tick_b = 1'b1; else tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
    tick_b = 1'b0;
    b = sel ? busy_b : busy_a;
    while (b && n < 400) begin
      ups += sel ? int'(upd_b) : int'(upd_a);
      n++;
      if (n == extra) begin
        if (sel) tick_b = 1'b1; else tick_a = 1'b1;
      end else begin
        tick_a = 1'b0;
        tick_b = 1'b0;
      end
      @(negedge clk);
      b = sel ? busy_b : busy_a;
    end
    tick_a = 1'b0;
    tick_b = 1'b0;
    last_n = n;
    last_ups = ups;
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; tick_a = 1'b0; tick_b = 1'b0;
    center_x = 10'd320; center_y = 10'd240; dx = 6'd0; dy = 6'd0;
    do_reset();

    check("rst_vx", vx_a, 5);
    check("rst_vy", vy_a, -3);
    check("rst_w", w_a, 2);
    check("rst_busy", busy_a, 0);
    check("rst_update", upd_a, 0);
    check("rst_overrun", ovr_a, 0);
    check("rst_bounce", {bx_a, by_a}, 0);

    // Free flight: latency and single update pulse.
    frame(1'b0, 0);
    check("t1_busy_len", last_n, 163);
    check("t1_updates", last_ups, 1);
    check("t1_vx", vx_a, 5);
    check("t1_vy", vy_a, -3);
    check("t1_w", w_a, 2);
    check("t1_bounce", {bx_a, by_a}, 0);

    // Right wall, moving outward.
    center_x = 10'd630;
    frame(1'b0, 0);
    check("t2_vx", vx_a, -5);
    check("t2_vy", vy_a, -3);
    check("t2_w", w_a, -2);
    check("t2_bx", bx_a, 1);
    check("t2_by", by_a, 0);
    @(negedge clk);
    check("t2_bx_pulse", bx_a, 0);

    // Still embedded but receding: no reflection.
    frame(1'b0, 0);
    check("t4_vx", vx_a, -5);
    check("t4_w", w_a, -2);
    check("t4_bx", bx_a, 0);

    // Reset during SETTLE aborts to IDLE with initial outputs.
    @(negedge clk);
    tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
    repeat (50) @(negedge clk);
    check("mid_busy_before", busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_vx", vx_a, 5);
    check("mid_rst_w", w_a, 2);
    rst = 1'b0;

    // Corner: right wall with vx>0 and top wall with vy<0.
    center_x = 10'd630; center_y = 10'd5;
    frame(1'b0, 0);
    check("t3_vx", vx_a, -5);
    check("t3_vy", vy_a, 3);
    check("t3_w", w_a, -2);
    check("t3_bxby", {bx_a, by_a}, 3);

    // run=0: tick ignored.
    center_x = 10'd320; center_y = 10'd240;
    @(negedge clk);
    run = 1'b0;
    tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
    last_ups = 0;
    repeat (5) begin
      last_ups += int'(upd_a);
      check("run0_busy", busy_a, 0);
      @(negedge clk);
    end
    check("run0_updates", last_ups, 0);
    run = 1'b1;

    // Left wall with vx=-32 saturates to +31.
    center_x = 10'd10;
    frame(1'b1, 0);
    check("t5_vx", vx_b, 31);
    check("t5_vy", vy_b, 30);
    check("t5_w", w_b, -2);
    check("t5_bx", bx_b, 1);

    // Second tick during SETTLE: overrun, still one update.
    center_x = 10'd320;
    frame(1'b1, 20);
    check("ovr_updates", last_ups, 1);
    check("ovr_busy_len", last_n, 163);
    check("ovr_flag_b", ovr_b, 1);
    check("ovr_flag_a", ovr_a, 0);
    check("ovr_vx", vx_b, 31);

    // Six more frames make eight accepted frames on instance b.
    repeat (6) frame(1'b1, 0);
`ifdef BOUNCE_GRAVITY_EN
    check("grav_vy", vy_b, 31);
`else
    check("grav_vy", vy_b, 30);
`endif
    check("grav_vx", vx_b, 31);
    check("grav_w", w_b, -2);
    check("ovr_sticky", ovr_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
